// File: rtl/sprite_renderer_pkg.sv
// Shared constants for the sprite renderer: colour/coordinate widths,
// sprite geometry and the transparency key.
package sprite_renderer_pkg;
  localparam int unsigned COLOR_W     = 12;
  localparam int unsigned COORD_W     = 12;
  localparam int unsigned SPRITE_LOG2 = 6;
  localparam int unsigned FRAME_LOG2  = 3;
  localparam int unsigned SPRITE_SIZE = 2 ** SPRITE_LOG2;
  localparam logic [COLOR_W-1:0] TRANS_COLOR = 12'hF0F;
endpackage

// File: rtl/anim_frame_counter.sv
// Animation frame sequencer: counts enabled vsync ticks and advances the
// frame index once every ANIM_DIV ticks, wrapping over all frames.
module anim_frame_counter
  import sprite_renderer_pkg::*;
#(
  parameter int unsigned ANIM_DIV   = 8,
  parameter int unsigned FRAME_LOG2 = sprite_renderer_pkg::FRAME_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vsync_tick,
  input  logic                  anim_en,
  output logic [FRAME_LOG2-1:0] frame_idx
);
  logic [7:0] tick_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt  <= '0;
      frame_idx <= '0;
    end else if (vsync_tick && anim_en) begin
      if (tick_cnt == 8'(ANIM_DIV - 1)) begin
        tick_cnt  <= '0;
        frame_idx <= frame_idx + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 8'd1;
      end
    end
  end
endmodule

// File: rtl/sprite_renderer.sv
// Sprite window test, RAM address generation and 3-stage colour pipeline
// producing a transparency-keyed sprite pixel for the colorizer.
module sprite_renderer
  import sprite_renderer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = sprite_renderer_pkg::COLOR_W,
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned SPRITE_LOG2 = sprite_renderer_pkg::SPRITE_LOG2,
  parameter int unsigned FRAME_LOG2  = sprite_renderer_pkg::FRAME_LOG2,
  parameter int unsigned ANIM_DIV    = 8,
  parameter logic [DATA_WIDTH-1:0] TRANS_COLOR = sprite_renderer_pkg::TRANS_COLOR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COORD_W-1:0]    pixel_row,
  input  logic [COORD_W-1:0]    pixel_column,
  input  logic                  video_on,
  input  logic                  vsync_tick,
  input  logic [COORD_W-1:0]    sprite_x,
  input  logic [COORD_W-1:0]    sprite_y,
  input  logic                  flip_h,
  input  logic                  anim_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] sprite_pixel,
  output logic                  sprite_hit,
  output logic [FRAME_LOG2-1:0] frame_idx
);
  logic [COORD_W-1:0]     sx, sy;
  logic                   flip;
  logic [COORD_W:0]       dx, dy;
  logic [SPRITE_LOG2-1:0] lx;
  logic                   in_win;
  logic                   v1, v2;

  // Position/flip only change at frame start so the sprite never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sx   <= '0;
      sy   <= '0;
      flip <= 1'b0;
    end else if (vsync_tick) begin
      sx   <= sprite_x;
      sy   <= sprite_y;
      flip <= flip_h;
    end
  end

  anim_frame_counter #(
    .ANIM_DIV   (ANIM_DIV),
    .FRAME_LOG2 (FRAME_LOG2)
  ) u_anim (
    .clk        (clk),
    .reset      (reset),
    .vsync_tick (vsync_tick),
    .anim_en    (anim_en),
    .frame_idx  (frame_idx)
  );

  // The extra MSB of dx/dy is the borrow; folding it into the upper-bits
  // zero test rejects both negative offsets and offsets past the sprite edge.
  always_comb begin
    dx     = {1'b0, pixel_column} - {1'b0, sx};
    dy     = {1'b0, pixel_row} - {1'b0, sy};
    in_win = video_on && (dx[COORD_W:SPRITE_LOG2] == '0) && (dy[COORD_W:SPRITE_LOG2] == '0);
    lx     = flip ? ~dx[SPRITE_LOG2-1:0] : dx[SPRITE_LOG2-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr     <= '0;
      v1           <= 1'b0;
      v2           <= 1'b0;
      sprite_hit   <= 1'b0;
      sprite_pixel <= '0;
    end else begin
      if (in_win)
        ram_addr <= {frame_idx, dy[SPRITE_LOG2-1:0], lx};
      v1 <= in_win;
      v2 <= v1;
      sprite_hit   <= v2 && (ram_q != TRANS_COLOR);
      sprite_pixel <= (v2 && (ram_q != TRANS_COLOR)) ? ram_q : '0;
    end
  end
endmodule

// File: tb/tb_sprite_renderer.sv
// Randomised and directed bench for sprite_renderer against a behavioural
// window/animation model and a registered-read sprite RAM.
module tb_sprite_renderer;
  localparam int unsigned ANIM_DIV = 8;

  typedef struct {
    logic        hit;
    logic [11:0] pix;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pixel_row = '0, pixel_column = '0;
  logic        video_on = 1'b0, vsync_tick = 1'b0;
  logic [11:0] sprite_x = '0, sprite_y = '0;
  logic        flip_h = 1'b0, anim_en = 1'b0;
  logic [14:0] ram_addr;
  logic [11:0] ram_q = '0;
  logic [11:0] sprite_pixel;
  logic        sprite_hit;
  logic [2:0]  frame_idx;

  logic [11:0] mem [0:32767];

  int          errors = 0;
  int          checks = 0;

  int          m_sx, m_sy, m_ticks;
  bit          m_flip;
  logic [14:0] m_last_addr, exp_addr;
  bit          addr_pending;
  exp_t        q[$];

  sprite_renderer #(
    .DATA_WIDTH  (12),
    .ADDR_WIDTH  (15),
    .SPRITE_LOG2 (6),
    .FRAME_LOG2  (3),
    .ANIM_DIV    (ANIM_DIV),
    .TRANS_COLOR (12'hF0F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_row    (pixel_row),
    .pixel_column (pixel_column),
    .video_on     (video_on),
    .vsync_tick   (vsync_tick),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .flip_h       (flip_h),
    .anim_en      (anim_en),
    .ram_addr     (ram_addr),
    .ram_q        (ram_q),
    .sprite_pixel (sprite_pixel),
    .sprite_hit   (sprite_hit),
    .frame_idx    (frame_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_flip = 0; m_ticks = 0;
    m_last_addr = '0; addr_pending = 0;
    q.delete();
  endtask

  // One pixel clock: check outputs due now, then apply new inputs and
  // predict their results from the geometric definition of the sprite.
  task automatic step(input logic [11:0] row, input logic [11:0] col, input logic von,
                      input logic vs, input logic [11:0] sx, input logic [11:0] sy,
                      input logic fl, input logic an);
    exp_t e;
    int dx, dy, lx, fr;
    bit inw;
    @(negedge clk);
    checks++;
    if (frame_idx !== 3'((m_ticks / ANIM_DIV) % 8)) begin
      errors++;
      $display("FAIL frame_idx got %0d want %0d", frame_idx, (m_ticks / ANIM_DIV) % 8);
    end
    if (addr_pending) begin
      checks++;
      if (ram_addr !== exp_addr) begin
        errors++;
        $display("FAIL ram_addr got %h want %h", ram_addr, exp_addr);
      end
    end
    if (q.size() == 3) begin
      e = q.pop_front();
      checks++;
      if (sprite_hit !== e.hit || sprite_pixel !== e.pix) begin
        errors++;
        $display("FAIL sprite_out got hit=%b pix=%h want hit=%b pix=%h",
                 sprite_hit, sprite_pixel, e.hit, e.pix);
      end
    end
    pixel_row = row; pixel_column = col; video_on = von; vsync_tick = vs;
    sprite_x = sx; sprite_y = sy; flip_h = fl; anim_en = an;
    dx  = int'(col) - m_sx;
    dy  = int'(row) - m_sy;
    inw = von && dx >= 0 && dx < 64 && dy >= 0 && dy < 64;
    lx  = m_flip ? 63 - dx : dx;
    fr  = (m_ticks / ANIM_DIV) % 8;
    if (inw) m_last_addr = 15'(fr * 4096 + dy * 64 + lx);
    exp_addr = m_last_addr;
    addr_pending = 1;
    e.hit = inw && (mem[m_last_addr] != 12'hF0F);
    e.pix = e.hit ? mem[m_last_addr] : 12'h000;
    q.push_back(e);
    if (vs) begin
      m_sx = int'(sx); m_sy = int'(sy); m_flip = fl;
      if (an) m_ticks++;
    end
  endtask

  task automatic pix(input int row, input int col);
    step(12'(row), 12'(col), 1'b1, 1'b0, sprite_x, sprite_y, flip_h, anim_en);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(12'd0, 12'd0, 1'b0, 1'b0, sprite_x, sprite_y, flip_h, anim_en);
  endtask

  task automatic vtick(input int sx, input int sy, input logic fl, input logic an);
    step(12'd0, 12'd0, 1'b0, 1'b1, 12'(sx), 12'(sy), fl, an);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (sprite_hit !== 1'b0 || sprite_pixel !== 12'h000 || ram_addr !== 15'h0 || frame_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got hit=%b pix=%h addr=%h frame=%0d want all zero",
               sprite_hit, sprite_pixel, ram_addr, frame_idx);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_hit();
    mem[15'h0000] = 12'h0F0;
    vtick(100, 50, 1'b0, 1'b0);
    pix(50, 100);
    pix(50, 101);
    pix(63, 120);
    idle(3);
  endtask

  task automatic test_flip();
    vtick(100, 50, 1'b1, 1'b0);
    pix(51, 100);
    pix(50, 163);
    idle(3);
    vtick(100, 50, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_transparent_edges();
    mem[15'd129] = 12'hF0F;
    pix(52, 101);
    pix(50, 164);
    pix(50, 99);
    pix(49, 100);
    pix(114, 100);
    step(12'd50, 12'd100, 1'b0, 1'b0, sprite_x, sprite_y, flip_h, anim_en);
    pix(50, 100);
    idle(3);
  endtask

  task automatic test_anim();
    for (int i = 0; i < 64; i++) vtick(100, 50, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) vtick(100, 50, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) vtick(100, 50, 1'b0, 1'b0);
    pix(50, 100);
    pix(60, 130);
    idle(3);
  endtask

  task automatic test_shadow();
    step(12'd50, 12'd100, 1'b1, 1'b0, 12'd200, 12'd50, 1'b0, 1'b0);
    pix(50, 200);
    idle(3);
    // vsync coinciding with an in-window pixel: that pixel uses old values
    step(12'd50, 12'd101, 1'b1, 1'b1, 12'd200, 12'd50, 1'b0, 1'b1);
    pix(50, 200);
    pix(50, 100);
    pix(70, 263);
    idle(3);
  endtask

  task automatic test_random();
    int row, col, sx, sy;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        sx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4040, 4095)) : int'($urandom_range(0, 4095));
        sy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4040, 4095)) : int'($urandom_range(0, 4095));
        step(12'(m_sy + $urandom_range(0, 70)), 12'(m_sx + $urandom_range(0, 70)),
             1'b1, 1'b1, 12'(sx), 12'(sy), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        row = m_sy + int'($urandom_range(0, 80)) - 8;
        col = m_sx + int'($urandom_range(0, 80)) - 8;
        step(12'(row), 12'(col), 1'($urandom_range(0, 9) != 0), 1'b0,
             sprite_x, sprite_y, flip_h, anim_en);
      end
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    vtick(100, 50, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) vtick(100, 50, 1'b0, 1'b1);
    mem[15'd4096] = 12'h123;
    mem[15'd4097] = 12'h456;
    mem[15'd4098] = 12'h789;
    pix(50, 100);
    pix(50, 101);
    pix(50, 102);
    pix(50, 100);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (sprite_hit !== 1'b0 || sprite_pixel !== 12'h000 || frame_idx !== 3'd0 || ram_addr !== 15'h0) begin
      errors++;
      $display("FAIL reset_async got hit=%b pix=%h frame=%0d addr=%h want zeros",
               sprite_hit, sprite_pixel, frame_idx, ram_addr);
    end
    video_on = 1'b0;
    vsync_tick = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sprite_hit !== 1'b0 || sprite_pixel !== 12'h000 || frame_idx !== 3'd0) begin
        errors++;
        $display("FAIL reset_release cycle %0d got hit=%b pix=%h frame=%0d want zeros",
                 i, sprite_hit, sprite_pixel, frame_idx);
      end
    end
    vtick(100, 50, 1'b0, 1'b0);
    pix(50, 100);
    idle(3);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 12'($urandom);
    model_reset();
    test_reset();
    test_basic_hit();
    test_flip();
    test_transparent_edges();
    test_anim();
    test_shadow();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_renderer.md
Name: sprite_renderer

Overview:
- Pixel-pipeline stage directly upstream and downstream of the sprite RAM (12-bit colour, 15-bit address, 1-cycle registered read).
- Takes the display timing generator's pixel_row/pixel_column and works out whether the pixel lies inside the sprite window.
- Drives the sprite RAM read address, with animation frame and horizontal flip applied.
- Consumes the RAM data and emits a registered, transparency-keyed sprite pixel plus hit flag for the colorizer.

Parameters:
- DATA_WIDTH, 12: colour word width; matches sprite RAM.
- ADDR_WIDTH, 15: sprite RAM address width; must equal 2*SPRITE_LOG2+FRAME_LOG2.
- SPRITE_LOG2, 6: sprite is 2**SPRITE_LOG2 square (64x64).
- FRAME_LOG2, 3: number of animation frames is 2**FRAME_LOG2 (8).
- ANIM_DIV, 8: vsync ticks per animation frame step; legal range is 1..255.
- TRANS_COLOR, 12'hF0F: colour key treated as transparent.

Ports:
- clk  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- pixel_row  in  12  current scan row.
- pixel_column  in  12  current scan column.
- video_on  in  1  high in active display area.
- vsync_tick  in  1  one-cycle pulse at start of each frame.
- sprite_x  in  12  requested sprite left column.
- sprite_y  in  12  requested sprite top row.
- flip_h  in  1  requested horizontal mirror.
- anim_en  in  1  enable animation stepping.
- ram_addr  out  ADDR_WIDTH  sprite RAM read_addr.
- ram_q  in  DATA_WIDTH  sprite RAM q, valid one cycle after ram_addr.
- sprite_pixel  out  DATA_WIDTH  sprite colour; 0 when no hit.
- sprite_hit  out  1  opaque sprite pixel present.
- frame_idx  out  FRAME_LOG2  current animation frame.

Behaviour:
- Reset values: ram_addr=0, sprite_pixel=0, sprite_hit=0, frame_idx=0, tick counter=0, shadow x/y/flip=0, pipeline valid bits=0.
- Shadow registers: sprite_x/sprite_y/flip_h are latched only in a cycle where vsync_tick=1, so the sprite never tears mid-frame. A position change takes effect from the next frame.
- Animation: on vsync_tick with anim_en=1, tick_cnt increments. When tick_cnt==ANIM_DIV-1 it wraps to 0 and frame_idx increments modulo 2**FRAME_LOG2 (7->0).
- With anim_en=0, tick_cnt and frame_idx hold.
- Window test: 13-bit unsigned arithmetic, dx=pixel_column-sx and dy=pixel_row-sy. in_win = video_on and no borrow in either subtraction and dx<2**SPRITE_LOG2 and dy<2**SPRITE_LOG2. There is no wrap: a sprite at x=4090 shows only columns 4090..4095.
- lx = flip ? (2**SPRITE_LOG2-1-dx) : dx.
- ram_addr = {frame_idx, dy[SPRITE_LOG2-1:0], lx[SPRITE_LOG2-1:0]}.
- Pipeline, with a fixed latency of 3 clocks from pixel_row/pixel_column to sprite_pixel/sprite_hit:
  - S1: ram_addr and v1=in_win registered.
  - S2: RAM presents ram_q; v2<=v1.
  - S3: sprite_hit<=v2 && (ram_q!=TRANS_COLOR); sprite_pixel<=that ? ram_q : 0.
- Outside the window, ram_addr holds its last value. The RAM is not written by this block.
- Simultaneous events:
  - A vsync_tick coinciding with an in-window pixel: the new frame_idx and shadow values apply to addresses issued from the following cycle. Pixels already in S2/S3 complete with the old values.
- Reset mid-operation: all stages are cleared immediately. sprite_hit stays 0 for at least 3 cycles after release. frame_idx restarts at 0.
- video_on low forces a miss regardless of coordinates.

Decomposition:
- Shared package holds:
  - SPRITE_LOG2, FRAME_LOG2, TRANS_COLOR and colour/coordinate widths.
  - The derived SPRITE_SIZE=2**SPRITE_LOG2.
- One sub-module, anim_frame_counter (vsync_tick, anim_en, ANIM_DIV -> frame_idx), holds the tick counter and frame wrap.
- Window/address logic and the 3-stage pipeline stay in sprite_renderer.

Test Plan:
- Reset, then vsync_tick with sprite_x=100, sprite_y=50, flip_h=0, frame_idx=0. Drive pixel (row 50, col 100), video_on=1 -> ram_addr=15'h0000 one cycle later. With RAM word 12'h0F0, sprite_pixel=12'h0F0 and sprite_hit=1 exactly 3 cycles after the input.
- Same setup with flip_h=1 latched, pixel (row 51, col 100) -> ram_addr={3'd0,6'd1,6'd63}=15'h007F.
- RAM word at the hit address = 12'hF0F -> sprite_hit=0, sprite_pixel=0. Pixel (row 50, col 164) with sprite_x=100 -> miss. Pixel col 99 -> miss. video_on=0 at (50,100) -> miss.
- anim_en=1, ANIM_DIV=8: 8 vsync_ticks -> frame_idx 0->1. 64 ticks -> wraps to 0. Drop anim_en -> frame_idx holds across 20 ticks.
- Change sprite_x 100->200 without vsync_tick -> pixel at col 100 still hits. After the next vsync_tick, col 200 hits and col 100 misses.
- Assert reset while hits are in the pipeline -> sprite_hit and sprite_pixel drop to 0 without waiting for a clock edge, and stay 0 for 3 cycles after release. frame_idx reads 0.
